// File: rtl/avalon_st_mux_pkg.sv
// Shared configuration, beat and state types for the Avalon-ST merge block
// and the benches that drive or observe it.
package avalon_st_mux_pkg;

    localparam int DATA_WIDTH    = 64;
    localparam int CHANNEL_WIDTH = 10;
    localparam int EMPTY_WIDTH   = $clog2(DATA_WIDTH / 8);
    localparam int TX_DIR        = 4;
    localparam int DIR_SEL_WIDTH = (TX_DIR == 1) ? 1 : $clog2(TX_DIR);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } mux_state_e;

    typedef logic [DATA_WIDTH-1:0]    data_q_t[$];
    typedef logic [CHANNEL_WIDTH-1:0] channel_q_t[$];
    typedef logic [EMPTY_WIDTH-1:0]   empty_q_t[$];
    typedef logic [DIR_SEL_WIDTH-1:0] dir_q_t[$];

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    data;
        logic                     sop;
        logic                     eop;
        logic [EMPTY_WIDTH-1:0]   empty;
        logic [CHANNEL_WIDTH-1:0] channel;
        logic [DIR_SEL_WIDTH-1:0] dir;
    } beat_t;

    // Index reached by stepping 'off' places past 'base' on a ring of n ports.
    function automatic int wrap_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/avalon_st_mux_rr_arbiter.sv
// Combinational round-robin pick: the first requester after last_grant, with wrap.
// The pointer register is owned by the caller.
module avalon_st_mux_rr_arbiter
    import avalon_st_mux_pkg::*;
#(
    parameter int N     = TX_DIR,
    parameter int SEL_W = DIR_SEL_WIDTH
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] last_grant,
    input  logic             enable,
    output logic [N-1:0]     grant_oh,
    output logic [SEL_W-1:0] grant_idx,
    output logic             grant_valid
);

    int cand;

    always_comb begin
        grant_oh    = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 0;
        // off runs 1..N so the previous winner is searched last.
        for (int off = 1; off <= N; off++) begin
            cand = wrap_idx(int'(last_grant), off, N);
            for (int k = 0; k < N; k++) begin
                if (enable && !grant_valid && (k == cand) && req[k]) begin
                    grant_valid = 1'b1;
                    grant_oh[k] = 1'b1;
                    grant_idx   = SEL_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/avalon_st_mux.sv
// Packet-aware N-to-1 Avalon-ST merge: round-robin per packet, registered
// source stage, each beat tagged with the index of the sink it came from.
module avalon_st_mux
    import avalon_st_mux_pkg::*;
(
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [TX_DIR-1:0][DATA_WIDTH-1:0]     snk_data_i,
    input  logic [TX_DIR-1:0]                     snk_startofpacket_i,
    input  logic [TX_DIR-1:0]                     snk_endofpacket_i,
    input  logic [TX_DIR-1:0]                     snk_valid_i,
    input  logic [TX_DIR-1:0][EMPTY_WIDTH-1:0]    snk_empty_i,
    input  logic [TX_DIR-1:0][CHANNEL_WIDTH-1:0]  snk_channel_i,
    output logic [TX_DIR-1:0]                     snk_ready_o,
    output logic [DATA_WIDTH-1:0]                 src_data_o,
    output logic                                  src_startofpacket_o,
    output logic                                  src_endofpacket_o,
    output logic                                  src_valid_o,
    output logic [EMPTY_WIDTH-1:0]                src_empty_o,
    output logic [CHANNEL_WIDTH-1:0]              src_channel_o,
    output logic [DIR_SEL_WIDTH-1:0]              src_dir_o,
    input  logic                                  src_ready_i
);

    // Handshake: a beat moves on any port exactly when its valid and ready are
    // both high at a rising clk_i edge; ready never depends on the same port's valid
    // once a packet is locked, and a held beat stays stable until accepted.

    mux_state_e                 state_q, state_d;
    logic [DIR_SEL_WIDTH-1:0]   lock_q, lock_d;
    logic [DIR_SEL_WIDTH-1:0]   last_grant_q, last_grant_d;

    logic [TX_DIR-1:0]          arb_oh;
    logic [DIR_SEL_WIDTH-1:0]   arb_idx;
    logic                       arb_valid;

    logic [TX_DIR-1:0]          grant_oh;
    logic [DIR_SEL_WIDTH-1:0]   grant_idx;
    logic                       grant_active;
    logic                       can_load;
    logic                       snk_xfer;

    beat_t                      sel_beat;
    beat_t                      src_q;
    logic                       src_valid_q;

    avalon_st_mux_rr_arbiter #(
        .N     (TX_DIR),
        .SEL_W (DIR_SEL_WIDTH)
    ) u_arb (
        .req         (snk_valid_i),
        .last_grant  (last_grant_q),
        .enable      (state_q == ST_IDLE),
        .grant_oh    (arb_oh),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    // Grant follows the arbiter while idle and is frozen on the lock otherwise.
    always_comb begin
        grant_oh     = arb_oh;
        grant_idx    = arb_idx;
        grant_active = arb_valid;
        if (state_q == ST_LOCKED) begin
            grant_oh     = '0;
            grant_idx    = lock_q;
            grant_active = 1'b1;
            for (int k = 0; k < TX_DIR; k++) begin
                if (DIR_SEL_WIDTH'(k) == lock_q) begin
                    grant_oh[k] = 1'b1;
                end
            end
        end
    end

    assign can_load    = ~src_valid_q | src_ready_i;
    assign snk_ready_o = (rst_i || !can_load || !grant_active) ? '0 : grant_oh;
    assign snk_xfer    = |(snk_valid_i & snk_ready_o);

    always_comb begin
        sel_beat = '0;
        for (int k = 0; k < TX_DIR; k++) begin
            if (grant_oh[k]) begin
                sel_beat.data    = snk_data_i[k];
                sel_beat.sop     = snk_startofpacket_i[k];
                sel_beat.eop     = snk_endofpacket_i[k];
                sel_beat.empty   = snk_empty_i[k];
                sel_beat.channel = snk_channel_i[k];
            end
        end
        sel_beat.dir = grant_idx;
    end

    // Any first beat locks, SOP or not; only an accepted EOP releases.
    always_comb begin
        state_d      = state_q;
        lock_d       = lock_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (snk_xfer) begin
                    if (sel_beat.eop) begin
                        last_grant_d = grant_idx;
                    end else begin
                        state_d = ST_LOCKED;
                        lock_d  = grant_idx;
                    end
                end
            end
            ST_LOCKED: begin
                if (snk_xfer && sel_beat.eop) begin
                    state_d      = ST_IDLE;
                    last_grant_d = lock_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            lock_q       <= '0;
            last_grant_q <= DIR_SEL_WIDTH'(TX_DIR - 1);
        end else begin
            state_q      <= state_d;
            lock_q       <= lock_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            src_valid_q <= 1'b0;
            src_q       <= '0;
        end else if (snk_xfer) begin
            src_valid_q <= 1'b1;
            src_q       <= sel_beat;
        end else if (can_load) begin
            src_valid_q <= 1'b0;
        end
    end

    assign src_valid_o         = src_valid_q;
    assign src_data_o          = src_q.data;
    assign src_startofpacket_o = src_q.sop;
    assign src_endofpacket_o   = src_q.eop;
    assign src_empty_o         = src_q.empty;
    assign src_channel_o       = src_q.channel;
    assign src_dir_o           = src_q.dir;

endmodule
